// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared glyph, digit-select and FSM definitions for the scan decoder.
package seg_pkg;

  // Active-low segment patterns on {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [2:0] SEL_ONES     = 3'b110;
  localparam logic [2:0] SEL_TENS     = 3'b101;
  localparam logic [2:0] SEL_HUNDREDS = 3'b011;
  localparam logic [2:0] SEL_NONE     = 3'b111;

  typedef enum logic {COLLECT, CHECK} state_e;

  // h*100 + t*10 + o built from shifts only.
  function automatic logic [9:0] bcd3_to_bin(input logic [3:0] h, input logic [3:0] t,
                                             input logic [3:0] o);
    logic [9:0] hh, tt, oo;
    hh = {6'd0, h};
    tt = {6'd0, t};
    oo = {6'd0, o};
    return (hh << 6) + (hh << 5) + (hh << 2) + (tt << 3) + (tt << 1) + oo;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// rtl/seg_glyph_decode.sv - combinational 7-segment glyph to BCD nibble decoder.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    valid_o  = 1'b1;
    nibble_o = 4'd0;
    case (seg_i)
      GLYPH_0:     nibble_o = 4'd0;
      GLYPH_1:     nibble_o = 4'd1;
      GLYPH_2:     nibble_o = 4'd2;
      GLYPH_3:     nibble_o = 4'd3;
      GLYPH_4:     nibble_o = 4'd4;
      GLYPH_5:     nibble_o = 4'd5;
      GLYPH_6:     nibble_o = 4'd6;
      GLYPH_7:     nibble_o = 4'd7;
      GLYPH_8:     nibble_o = 4'd8;
      GLYPH_9:     nibble_o = 4'd9;
      GLYPH_BLANK: nibble_o = 4'd0;  // leading-zero blanking
      default:     valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers the 3-digit score from scanned segment/digit-select lines.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int MIN_DWELL     = 16,
  parameter int FRAMES_STABLE = 2,
  parameter int TIMEOUT       = 65536,
  parameter int BIN_W         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       segsig,
  input  logic [2:0]       bitsig,
  output logic [BIN_W-1:0] bin,
  output logic             bin_valid,
  output logic [11:0]      digits,
  output logic             glyph_err,
  output logic             stale
);

  localparam int DW_W = $clog2(MIN_DWELL + 1);
  localparam int ST_W = $clog2(FRAMES_STABLE + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(MIN_DWELL - 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(FRAMES_STABLE);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

  logic            dp_unused;
  logic [6:0]      seg_s1_q, seg_s2_q;
  logic [2:0]      bit_s1_q, bit_s2_q, bit_prev_q;
  state_e          state_q, state_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic            fired_q, fired_d;
  logic [2:0]      mask_q, mask_d;
  logic [2:0][3:0] nib_q, nib_d;
  logic [BIN_W-1:0] cand_q, cand_d, bin_q, bin_d;
  logic [ST_W-1:0] stable_q, stable_d;
  logic            confirmed_q, confirmed_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            stale_q, stale_d;
  logic            bin_valid_q, bin_valid_d;
  logic            glyph_err_q, glyph_err_d;
  logic [11:0]     digits_q, digits_d;

  logic            glyph_ok;
  logic [3:0]      glyph_nib;
  logic [2:0]      sel_oh;
  logic            sel_legal, same, idle, hit;
  logic [BIN_W-1:0] value;

  assign dp_unused = segsig[7];

  seg_glyph_decode u_glyph_decode (
    .seg_i    (seg_s2_q),
    .valid_o  (glyph_ok),
    .nibble_o (glyph_nib)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1_q   <= GLYPH_BLANK;
      seg_s2_q   <= GLYPH_BLANK;
      bit_s1_q   <= SEL_NONE;
      bit_s2_q   <= SEL_NONE;
      bit_prev_q <= SEL_NONE;
    end else begin
      seg_s1_q   <= segsig[6:0];
      seg_s2_q   <= seg_s1_q;
      bit_s1_q   <= bitsig;
      bit_s2_q   <= bit_s1_q;
      bit_prev_q <= bit_s2_q;
    end
  end

  assign sel_oh    = ~bit_s2_q;
  assign sel_legal = (bit_s2_q == SEL_ONES) || (bit_s2_q == SEL_TENS) ||
                     (bit_s2_q == SEL_HUNDREDS);
  assign same      = (bit_s2_q == bit_prev_q);
  assign idle      = (bit_s2_q == SEL_NONE);
  // fired_q limits each dwell period to a single capture/error event.
  assign hit       = same && !idle && (dwell_q == DW_MAX) && !fired_q;
  assign value     = BIN_W'(bcd3_to_bin(nib_q[2], nib_q[1], nib_q[0]));

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    fired_d     = fired_q;
    mask_d      = mask_q;
    nib_d       = nib_q;
    cand_d      = cand_q;
    bin_d       = bin_q;
    stable_d    = stable_q;
    confirmed_d = confirmed_q;
    tmo_d       = tmo_q;
    stale_d     = stale_q;
    digits_d    = digits_q;
    bin_valid_d = 1'b0;
    glyph_err_d = 1'b0;

    if (!same || idle) begin
      dwell_d = '0;
      fired_d = 1'b0;
    end else if (dwell_q != DW_MAX) begin
      dwell_d = dwell_q + 1'b1;
    end
    if (hit) fired_d = 1'b1;

    case (state_q)
      COLLECT: begin
        if (tmo_q != TO_MAX) tmo_d = tmo_q + 1'b1;
        if (tmo_d == TO_MAX) stale_d = 1'b1;
        if (hit) begin
          if (!sel_legal) begin
            glyph_err_d = 1'b1;
            mask_d      = '0;
          end else if ((mask_q & sel_oh) == 3'b000) begin
            if (!glyph_ok) begin
              glyph_err_d = 1'b1;
              mask_d      = '0;
            end else begin
              for (int i = 0; i < 3; i++) begin
                if (sel_oh[i]) nib_d[i] = glyph_nib;
              end
              mask_d = mask_q | sel_oh;
              if ((mask_q | sel_oh) == 3'b111) state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        digits_d = nib_q;
        if (value == cand_q) begin
          if (stable_q != ST_MAX) stable_d = stable_q + 1'b1;
        end else begin
          cand_d   = value;
          stable_d = ST_W'(1);
        end
        if ((stable_d == ST_MAX) && ((value != bin_q) || !confirmed_q)) begin
          bin_d       = value;
          bin_valid_d = 1'b1;
          confirmed_d = 1'b1;
        end
        mask_d  = '0;
        tmo_d   = '0;
        stale_d = 1'b0;
        state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      dwell_q     <= '0;
      fired_q     <= 1'b0;
      mask_q      <= '0;
      nib_q       <= '0;
      cand_q      <= '0;
      bin_q       <= '0;
      stable_q    <= '0;
      confirmed_q <= 1'b0;
      tmo_q       <= '0;
      stale_q     <= 1'b0;
      digits_q    <= '0;
      bin_valid_q <= 1'b0;
      glyph_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      fired_q     <= fired_d;
      mask_q      <= mask_d;
      nib_q       <= nib_d;
      cand_q      <= cand_d;
      bin_q       <= bin_d;
      stable_q    <= stable_d;
      confirmed_q <= confirmed_d;
      tmo_q       <= tmo_d;
      stale_q     <= stale_d;
      digits_q    <= digits_d;
      bin_valid_q <= bin_valid_d;
      glyph_err_q <= glyph_err_d;
    end
  end

  assign bin       = bin_q;
  assign bin_valid = bin_valid_q;
  assign digits    = digits_q;
  assign glyph_err = glyph_err_q;
  assign stale     = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed and randomized scans checked against a frame-level model.
module tb_seg_scan_decoder;

  localparam int FS = 2;
  localparam int TO = 2048;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] segsig = 8'hFF;
  logic [2:0] bitsig = 3'b111;
  logic [9:0] bin;
  logic       bin_valid;
  logic [11:0] digits;
  logic       glyph_err;
  logic       stale;

  seg_scan_decoder #(
    .MIN_DWELL(16), .FRAMES_STABLE(FS), .TIMEOUT(TO), .BIN_W(10)
  ) dut (
    .clk(clk), .reset(reset), .segsig(segsig), .bitsig(bitsig),
    .bin(bin), .bin_valid(bin_valid), .digits(digits),
    .glyph_err(glyph_err), .stale(stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_seen = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (bin_valid === 1'b1) pulse_seen++;
    if (glyph_err === 1'b1) err_seen++;
  end

  logic [7:0] gl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int m_mask, m_cand, m_stable, m_bin, m_digits, exp_pulse, exp_err;
  int m_nib [3];
  bit m_conf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int glyph_val(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (gl[i][6:0] == s) return i;
    if (s == 7'h7F) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    m_mask = 0; m_cand = 0; m_stable = 0; m_bin = 0; m_digits = 0; m_conf = 0;
    for (int i = 0; i < 3; i++) m_nib[i] = 0;
  endtask

  task automatic frame_done();
    int v;
    v = m_nib[2] * 100 + m_nib[1] * 10 + m_nib[0];
    m_digits = m_nib[2] * 256 + m_nib[1] * 16 + m_nib[0];
    if (v == m_cand) begin
      if (m_stable < FS) m_stable++;
    end else begin
      m_cand = v;
      m_stable = 1;
    end
    if (m_stable == FS && (v != m_bin || !m_conf)) begin
      m_bin = v;
      m_conf = 1;
      exp_pulse++;
    end
    m_mask = 0;
  endtask

  // Short holds (<=10) never capture; long holds (>=20) always reach the capture point.
  task automatic model_step(input logic [2:0] sel, input logic [7:0] seg, input bit long_hold);
    int idx, g;
    if (!long_hold || sel == 3'b111) return;
    case (sel)
      3'b110: idx = 0;
      3'b101: idx = 1;
      3'b011: idx = 2;
      default: idx = -1;
    endcase
    if (idx < 0) begin
      exp_err++; m_mask = 0; return;
    end
    if (m_mask[idx]) return;
    g = glyph_val(seg[6:0]);
    if (g < 0) begin
      exp_err++; m_mask = 0; return;
    end
    m_nib[idx] = g;
    m_mask = m_mask | (1 << idx);
    if (m_mask == 7) frame_done();
  endtask

  task automatic show(input logic [2:0] sel, input logic [7:0] seg, input int n);
    bitsig = sel;
    segsig = seg;
    repeat (n) tick();
    model_step(sel, seg, n >= 20);
  endtask

  task automatic frame_val(input int v, input int dw, input bit shuf, input int bad_pos,
                           input logic [7:0] bad_seg);
    logic [7:0] seg [3];
    logic [2:0] sel [3];
    logic [7:0] dpx;
    int ord [3];
    int h, t, o, tmp, j;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    seg[2] = (h == 0) ? 8'hFF : gl[h];
    seg[1] = (h == 0 && t == 0) ? 8'hFF : gl[t];
    seg[0] = gl[o];
    if (bad_pos >= 0) seg[bad_pos] = bad_seg;
    sel[0] = 3'b110; sel[1] = 3'b101; sel[2] = 3'b011;
    ord[0] = 2; ord[1] = 1; ord[2] = 0;
    if (shuf) begin
      for (int i = 2; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
    end
    for (int k = 0; k < 3; k++) begin
      dpx = shuf ? (8'($urandom_range(1, 0)) << 7) : 8'h00;
      show(sel[ord[k]], seg[ord[k]] ^ dpx, dw);
    end
    show(3'b111, 8'hFF, 6);
  endtask

  task automatic verify(input string tag, input bit exp_stale);
    chk({tag, " bin"}, 32'(bin), 32'(m_bin));
    chk({tag, " digits"}, 32'(digits), 32'(m_digits));
    chk({tag, " pulses"}, 32'(pulse_seen), 32'(exp_pulse));
    chk({tag, " glyph_errs"}, 32'(err_seen), 32'(exp_err));
    chk({tag, " stale"}, 32'(stale), 32'(exp_stale));
  endtask

  initial begin
    int scores [4];
    int v, nrep;
    exp_pulse = 0;
    exp_err = 0;
    model_reset();

    repeat (4) tick();
    chk("reset bin", 32'(bin), 0);
    chk("reset bin_valid", 32'(bin_valid), 0);
    chk("reset digits", 32'(digits), 0);
    chk("reset glyph_err", 32'(glyph_err), 0);
    chk("reset stale", 32'(stale), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      frame_val(37, 20, 0, -1, 8'h00);
      verify("blank37", 0);
    end

    scores = '{5, 9, 21, 48};
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 3; r++) begin
        frame_val(scores[s], 20, 0, -1, 8'h00);
        verify("step", 0);
      end
    end

    show(3'b011, 8'hFF, 20);
    show(3'b101, gl[3], 10);
    show(3'b110, gl[7], 20);
    show(3'b111, 8'hFF, 6);
    verify("short tens", 0);
    show(3'b101, gl[3], 20);
    show(3'b111, 8'hFF, 6);
    verify("late tens", 0);
    frame_val(37, 20, 0, -1, 8'h00);
    verify("after short", 0);

    frame_val(37, 20, 0, 0, 8'hFE);
    verify("bad glyph", 0);
    frame_val(37, 20, 0, -1, 8'h00);
    verify("after bad", 0);

    show(3'b100, gl[1], 20);
    show(3'b111, 8'hFF, 6);
    verify("multi-hot", 0);
    show(3'b111, 8'hFF, TO / 2);
    verify("idle half", 0);
    show(3'b111, 8'hFF, TO);
    verify("idle stale", 1);
    frame_val(37, 20, 0, -1, 8'h00);
    verify("resume", 0);

    for (int n = 0; n < 14; n++) begin
      v = $urandom_range(999, 0);
      nrep = $urandom_range(3, 2);
      for (int r = 0; r < nrep; r++) begin
        if ($urandom_range(7, 0) == 0)
          frame_val(v, $urandom_range(24, 20), 1, $urandom_range(2, 0),
                    8'($urandom_range(255, 0)));
        else
          frame_val(v, $urandom_range(24, 20), 1, -1, 8'h00);
        verify("random", 0);
      end
    end

    show(3'b011, 8'hFF, 20);
    show(3'b101, gl[1], 20);
    bitsig = 3'b111;
    segsig = 8'hFF;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk("midreset bin_valid", 32'(bin_valid), 0);
    verify("midreset", 0);
    for (int r = 0; r < 2; r++) begin
      frame_val(12, 20, 0, -1, 8'h00);
      verify("after reset 012", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
